bp_update_scheduler: RTL and testbench

- Shares the single table port of the gshare predictor between two users: fetch-stage prediction lookups and commit-stage branch-outcome updates.
- Accepts up to two resolved branches per cycle from the commit stage and buffers them in program order in a FIFO.
- Gives each cycle's table slot to either a lookup or one update.
- Lookups normally win. A hysteresis drain state, plus a starvation timer, keeps the FIFO bounded and keeps predictor training timely.

---
 rtl/bp_update_scheduler.sv | 176 +++++++++++++++++
 tb/tb_bp_update_scheduler.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bp_update_scheduler.sv
// ============================================================================
// Module  : bp_update_scheduler
// Brief   : Arbitrates the gshare table port between fetch lookups and
//           FIFO-buffered commit updates, with hysteresis drain and starvation.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_update_scheduler #(
    parameter int DEPTH    = 8,
    parameter int HWM      = 6,
    parameter int LWM      = 2,
    parameter int MAX_WAIT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cm0_valid,
    input  logic [31:0]              cm0_pc,
    input  logic                     cm0_taken,
    input  logic                     cm1_valid,
    input  logic [31:0]              cm1_pc,
    input  logic                     cm1_taken,
    output logic                     cm_ready,
    input  logic                     lookup_req,
    output logic                     lookup_grant,
    output logic                     upd_valid,
    output logic [31:0]              upd_pc,
    output logic                     upd_taken,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow_err
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam int c_WW = $clog2(MAX_WAIT + 1);

    localparam logic [c_CW-1:0] c_READY_MAX = c_CW'(DEPTH - 2);
    localparam logic [c_CW-1:0] c_HWM       = c_CW'(HWM);
    localparam logic [c_CW-1:0] c_LWM       = c_CW'(LWM);
    localparam logic [c_WW-1:0] c_MAX_WAIT  = c_WW'(MAX_WAIT);

    localparam logic [0:0] c_S_NORMAL = 1'b0;
    localparam logic [0:0] c_S_DRAIN  = 1'b1;

    logic [31:0]      r_pc_mem [DEPTH];
    logic             r_tk_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic [c_WW-1:0]  r_wait;
    logic             r_ovf;
    logic [0:0]       r_state;

    logic [0:0]       w_state_nxt;
    logic             w_cm_ready;
    logic             w_enq0;
    logic             w_enq1;
    logic [1:0]       w_n_enq;
    logic [c_AW-1:0]  w_wr_ptr1;
    logic             w_empty;
    logic             w_starve;
    logic             w_grant;
    logic             w_upd_valid;
    logic             w_pop;
    logic [c_CW-1:0]  w_count_nxt;
    logic [c_WW-1:0]  w_wait_nxt;

    // Readiness is from registered count only, so a same-cycle pop never
    // creates a combinational path from the arbiter back to the commit stage.
    assign w_cm_ready = (r_count <= c_READY_MAX);
    assign w_enq0     = w_cm_ready & cm0_valid;
    assign w_enq1     = w_cm_ready & cm1_valid;
    assign w_n_enq    = {1'b0, w_enq0} + {1'b0, w_enq1};
    assign w_wr_ptr1  = r_wr_ptr + {{(c_AW-1){1'b0}}, w_enq0};

    assign w_empty    = (r_count == '0);
    assign w_starve   = (r_wait >= c_MAX_WAIT);
    assign w_pop      = w_upd_valid;

    assign w_count_nxt = r_count
                       + {{(c_CW-2){1'b0}}, w_n_enq}
                       - {{(c_CW-1){1'b0}}, w_pop};

    always_comb begin
        w_wait_nxt = r_wait;
        if (w_pop || w_empty) begin
            w_wait_nxt = '0;
        end else if (r_wait < c_MAX_WAIT) begin
            w_wait_nxt = r_wait + c_WW'(1);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_enq0) begin
            r_pc_mem[r_wr_ptr] <= cm0_pc;
            r_tk_mem[r_wr_ptr] <= cm0_taken;
        end
        if (w_enq1) begin
            r_pc_mem[w_wr_ptr1] <= cm1_pc;
            r_tk_mem[w_wr_ptr1] <= cm1_taken;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_wait   <= '0;
            r_ovf    <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + c_AW'(w_n_enq);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count <= w_count_nxt;
            r_wait  <= w_wait_nxt;
            if (!w_cm_ready && (cm0_valid || cm1_valid)) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_NORMAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: hysteresis evaluated on the post-update occupancy
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_NORMAL: if (w_count_nxt >= c_HWM) w_state_nxt = c_S_DRAIN;
            c_S_DRAIN:  if (w_count_nxt <= c_LWM) w_state_nxt = c_S_NORMAL;
            default:    w_state_nxt = c_S_NORMAL;
        endcase
    end

    // Outputs: port ownership for the current cycle
    always_comb begin
        w_grant     = 1'b0;
        w_upd_valid = 1'b0;
        case (r_state)
            c_S_NORMAL: begin
                if (lookup_req && !w_starve) begin
                    w_grant = 1'b1;
                end else begin
                    w_upd_valid = !w_empty;
                end
            end
            c_S_DRAIN: begin
                w_upd_valid = !w_empty;
            end
            default: begin
                w_grant     = 1'b0;
                w_upd_valid = 1'b0;
            end
        endcase
    end

    assign cm_ready     = w_cm_ready;
    assign lookup_grant = w_grant;
    assign upd_valid    = w_upd_valid;
    assign upd_pc       = w_upd_valid ? r_pc_mem[r_rd_ptr] : 32'h0;
    assign upd_taken    = w_upd_valid ? r_tk_mem[r_rd_ptr] : 1'b0;
    assign fifo_count   = r_count;
    assign overflow_err = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_bp_update_scheduler.sv
// ============================================================================
// Module  : tb_bp_update_scheduler
// Brief   : Directed scoreboard bench for bp_update_scheduler.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_bp_update_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        cm0_valid, cm0_taken, cm1_valid, cm1_taken;
    logic [31:0] cm0_pc, cm1_pc;
    logic        cm_ready, lookup_req, lookup_grant;
    logic        upd_valid, upd_taken, overflow_err;
    logic [31:0] upd_pc;
    logic [3:0]  fifo_count;

    typedef struct packed {
        logic [31:0] pc;
        logic        tk;
    } upd_t;

    upd_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    bp_update_scheduler #(.DEPTH(8), .HWM(6), .LWM(2), .MAX_WAIT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .cm0_valid    (cm0_valid),
        .cm0_pc       (cm0_pc),
        .cm0_taken    (cm0_taken),
        .cm1_valid    (cm1_valid),
        .cm1_pc       (cm1_pc),
        .cm1_taken    (cm1_taken),
        .cm_ready     (cm_ready),
        .lookup_req   (lookup_req),
        .lookup_grant (lookup_grant),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .fifo_count   (fifo_count),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every presented update must match the oldest commit
    always @(negedge clk) begin
        if (!rst) begin
            chk("grant_upd_exclusive", 32'(lookup_grant & upd_valid), 32'h0);
            if (upd_valid) begin
                if (sb.size() == 0) begin
                    chk("upd_unexpected", 32'(upd_valid), 32'h0);
                end else begin
                    upd_t e;
                    e = sb.pop_front();
                    chk("upd_pc", upd_pc, e.pc);
                    chk("upd_taken", 32'(upd_taken), 32'(e.tk));
                end
            end else begin
                chk("upd_pc_idle", upd_pc, 32'h0);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
        cm0_valid = 1'b0; cm0_pc = '0; cm0_taken = 1'b0;
        cm1_valid = 1'b0; cm1_pc = '0; cm1_taken = 1'b0;
    endtask

    task automatic commit0(input logic [31:0] pc, input logic tk, input bit expect_accept);
        cm0_valid = 1'b1; cm0_pc = pc; cm0_taken = tk;
        if (expect_accept) sb.push_back('{pc: pc, tk: tk});
    endtask

    task automatic commit2(input logic [31:0] pc0, input logic tk0,
                           input logic [31:0] pc1, input logic tk1);
        commit0(pc0, tk0, 1'b1);
        cm1_valid = 1'b1; cm1_pc = pc1; cm1_taken = tk1;
        sb.push_back('{pc: pc1, tk: tk1});
    endtask

    task automatic ck(input logic g, input logic u, input int cnt, input string tag);
        @(negedge clk);
        chk({tag, "_grant"}, 32'(lookup_grant), 32'(g));
        chk({tag, "_upd"},   32'(upd_valid),    32'(u));
        chk({tag, "_count"}, 32'(fifo_count),   32'(cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        rst = 1'b1; lookup_req = 1'b0;
        cm0_valid = 1'b0; cm0_pc = '0; cm0_taken = 1'b0;
        cm1_valid = 1'b0; cm1_pc = '0; cm1_taken = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_count", 32'(fifo_count), 32'h0);
        chk("rst_ready", 32'(cm_ready), 32'h1);
        chk("rst_upd", 32'(upd_valid), 32'h0);
        chk("rst_grant", 32'(lookup_grant), 32'h0);
        chk("rst_ovf", 32'(overflow_err), 32'h0);
        rst = 1'b0;
        nxt();

        // Single commit, idle fetch
        commit0(32'h100, 1'b1, 1'b1);
        ck(0, 0, 0, "t1_c0"); nxt();
        ck(0, 1, 1, "t1_c1"); nxt();
        ck(0, 0, 0, "t1_c2"); nxt();

        // Dual commit ordering
        commit2(32'h200, 1'b0, 32'h204, 1'b1);
        ck(0, 0, 0, "t2_c0"); nxt();
        ck(0, 1, 2, "t2_c1"); nxt();
        ck(0, 1, 1, "t2_c2"); nxt();
        ck(0, 0, 0, "t2_c3"); nxt();

        // Lookup priority and starvation, then a second round proving the wait clears
        lookup_req = 1'b1;
        commit0(32'h300, 1'b0, 1'b1);
        ck(1, 0, 0, "t3_c0"); nxt();
        for (int k = 1; k <= 15; k++) begin
            ck(1, 0, 1, "t3_wait"); nxt();
        end
        commit0(32'h304, 1'b1, 1'b1);
        ck(0, 1, 1, "t3_force"); nxt();
        for (int k = 1; k <= 15; k++) begin
            ck(1, 0, 1, "t3_wait2"); nxt();
        end
        ck(0, 1, 1, "t3_force2"); nxt();
        ck(1, 0, 0, "t3_empty"); nxt();

        // Drain hysteresis
        commit2(32'h400, 1'b1, 32'h404, 1'b0);
        ck(1, 0, 0, "t4_c0"); nxt();
        commit2(32'h408, 1'b1, 32'h40c, 1'b1);
        ck(1, 0, 2, "t4_c1"); nxt();
        commit2(32'h410, 1'b0, 32'h414, 1'b1);
        ck(1, 0, 4, "t4_c2"); nxt();
        for (int k = 0; k < 4; k++) begin
            ck(0, 1, 6 - k, "t4_drain"); nxt();
        end

        // Overflow: refill into DRAIN, reach 7, then a dropped commit
        commit2(32'h500, 1'b0, 32'h504, 1'b1);
        ck(1, 0, 2, "t4_exit"); nxt();
        commit2(32'h508, 1'b1, 32'h50c, 1'b0);
        ck(1, 0, 4, "t5_c1");
        chk("t5_ready4", 32'(cm_ready), 32'h1); nxt();
        commit2(32'h510, 1'b1, 32'h514, 1'b1);
        ck(0, 1, 6, "t5_c2");
        chk("t5_ready6", 32'(cm_ready), 32'h1); nxt();
        commit0(32'h5ff, 1'b1, 1'b0);
        ck(0, 1, 7, "t5_full");
        chk("t5_ready7", 32'(cm_ready), 32'h0);
        chk("t5_ovf_pre", 32'(overflow_err), 32'h0); nxt();
        ck(0, 1, 6, "t5_drop");
        chk("t5_ovf_set", 32'(overflow_err), 32'h1); nxt();
        ck(0, 1, 5, "t5_sticky");
        chk("t5_ovf_hold", 32'(overflow_err), 32'h1);

        // Async reset mid-drain at count 5
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("t6_count", 32'(fifo_count), 32'h0);
        chk("t6_upd", 32'(upd_valid), 32'h0);
        chk("t6_ready", 32'(cm_ready), 32'h1);
        chk("t6_ovf", 32'(overflow_err), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        nxt();
        commit0(32'h600, 1'b1, 1'b1);
        ck(1, 0, 0, "t6_c0"); nxt();
        ck(1, 0, 1, "t6_normal"); nxt();
        lookup_req = 1'b0;
        ck(0, 1, 1, "t6_idle"); nxt();
        ck(0, 0, 0, "t6_done");

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
